// File: rtl/obj_move_pkg.sv
// Shared types and default constants for the object move scheduler.
package obj_move_pkg;

    localparam int unsigned NUM_OBJ = 4;
    localparam int unsigned X_MAX   = 639;
    localparam int unsigned Y_MAX   = 479;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned DIR_W   = 4;

    // Field order matches the Direction port: bit3 up .. bit0 right.
    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LATCH  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/obj_step_clamp.sv
// Combinational step-and-clamp for one object's x and y, shared across objects.
module obj_step_clamp
    import obj_move_pkg::*;
#(
    parameter int unsigned STEP = 1
) (
    input  logic [COORD_W-1:0] x_cur,
    input  logic [COORD_W-1:0] y_cur,
    input  logic [COORD_W-1:0] x_max,
    input  logic [COORD_W-1:0] y_max,
    input  dir_t               dir,
    output logic [COORD_W-1:0] x_next_c,
    output logic [COORD_W-1:0] y_next_c
);

    localparam int unsigned CW1 = COORD_W + 1;

    // One extra bit: an underflowing subtract sets the top bit, an overflow exceeds max.
    function automatic logic [COORD_W-1:0] step_axis(
        input logic [COORD_W-1:0] cur,
        input logic               dec,
        input logic               inc,
        input logic [COORD_W-1:0] max
    );
        logic [CW1-1:0] r;
        r = {1'b0, cur};
        if (dec && !inc) begin
            r = r - CW1'(STEP);
            if (r[COORD_W]) begin
                r = '0;
            end
        end else if (inc && !dec) begin
            r = r + CW1'(STEP);
            if (r > {1'b0, max}) begin
                r = {1'b0, max};
            end
        end
        return r[COORD_W-1:0];
    endfunction

    always_comb begin
        x_next_c = step_axis(x_cur, dir.left, dir.right, x_max);
        y_next_c = step_axis(y_cur, dir.up, dir.down, y_max);
    end

endmodule

// File: rtl/obj_move_scheduler.sv
// Per-frame round-robin position updater for NUM_OBJ objects.
// Define OBJ_MOVE_DIAGONAL_EN to allow x and y to step in the same update.
module obj_move_scheduler #(
    parameter int unsigned NUM_OBJ = obj_move_pkg::NUM_OBJ,
    parameter int unsigned X_MAX   = obj_move_pkg::X_MAX,
    parameter int unsigned Y_MAX   = obj_move_pkg::Y_MAX,
    parameter int unsigned STEP    = 1,
    parameter int unsigned X_INIT  = 370,
    parameter int unsigned Y_INIT  = 240
) (
    input  logic                                               Clock,
    input  logic                                               Reset,
    input  logic                                               FrameTick,
    input  logic [NUM_OBJ-1:0]                                 Enable,
    input  logic [NUM_OBJ-1:0][obj_move_pkg::DIR_W-1:0]        Direction,
    output logic [NUM_OBJ-1:0][obj_move_pkg::COORD_W-1:0]      x_pos,
    output logic [NUM_OBJ-1:0][obj_move_pkg::COORD_W-1:0]      y_pos,
    output logic [NUM_OBJ-1:0]                                 Grant,
    output logic                                               Busy,
    output logic                                               Done,
    output logic                                               Overrun
);

    import obj_move_pkg::*;

    localparam int unsigned IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

    localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
    localparam logic [1:0] S_LATCH  = 2'(ST_LATCH);
    localparam logic [1:0] S_UPDATE = 2'(ST_UPDATE);
    localparam logic [1:0] S_DONE   = 2'(ST_DONE);

    logic [1:0]               state;
    logic [1:0]               state_next;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         idx_next;
    logic [NUM_OBJ-1:0]       grant_next;
    logic                     busy_next;
    logic                     done_next;
    logic                     overrun_next;

    logic [NUM_OBJ-1:0]       en_q;
    dir_t [NUM_OBJ-1:0]       dir_q;
    dir_t                     sel_dir_c;
    dir_t                     eff_dir_c;
    logic [COORD_W-1:0]       x_next_c;
    logic [COORD_W-1:0]       y_next_c;

    // Next state and next registered outputs.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        grant_next   = '0;
        busy_next    = 1'b0;
        done_next    = 1'b0;
        overrun_next = FrameTick && (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (FrameTick) begin
                    state_next = S_LATCH;
                end
            end
            S_LATCH: begin
                state_next = S_UPDATE;
                idx_next   = '0;
            end
            S_UPDATE: begin
                if (idx == IDX_W'(NUM_OBJ - 1)) begin
                    state_next = S_DONE;
                end else begin
                    idx_next = idx + IDX_W'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
        done_next = (state_next == S_DONE);
        if (state_next == S_UPDATE) begin
            grant_next[idx_next] = 1'b1;
        end
    end

    // Disabled objects still get their slot but step with no direction.
    always_comb begin
        sel_dir_c = en_q[idx] ? dir_q[idx] : '0;
`ifdef OBJ_MOVE_DIAGONAL_EN
        eff_dir_c = sel_dir_c;
`else
        eff_dir_c = sel_dir_c;
        if (sel_dir_c.up ^ sel_dir_c.down) begin
            eff_dir_c.left  = 1'b0;
            eff_dir_c.right = 1'b0;
        end
`endif
    end

    obj_step_clamp #(
        .STEP (STEP)
    ) u_step (
        .x_cur    (x_pos[idx]),
        .y_cur    (y_pos[idx]),
        .x_max    (COORD_W'(X_MAX)),
        .y_max    (COORD_W'(Y_MAX)),
        .dir      (eff_dir_c),
        .x_next_c (x_next_c),
        .y_next_c (y_next_c)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            en_q    <= '0;
            dir_q   <= '0;
            Grant   <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Overrun <= 1'b0;
            for (int i = 0; i < int'(NUM_OBJ); i++) begin
                x_pos[i] <= COORD_W'(X_INIT);
                y_pos[i] <= COORD_W'(Y_INIT);
            end
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            Grant   <= grant_next;
            Busy    <= busy_next;
            Done    <= done_next;
            Overrun <= overrun_next;
            if (state == S_LATCH) begin
                en_q  <= Enable;
                dir_q <= Direction;
            end
            if (state == S_UPDATE) begin
                x_pos[idx] <= x_next_c;
                y_pos[idx] <= y_next_c;
            end
        end
    end

endmodule

// File: tb/tb_obj_move_scheduler.sv
// Scoreboard bench for obj_move_scheduler; honours OBJ_MOVE_DIAGONAL_EN like the DUT.
module tb_obj_move_scheduler;

    logic                 Clock;
    logic                 Reset;
    logic                 FrameTick;
    logic [3:0]           Enable;
    logic [3:0][3:0]      Direction;
    logic [3:0][9:0]      x_pos;
    logic [3:0][9:0]      y_pos;
    logic [3:0]           Grant;
    logic                 Busy;
    logic                 Done;
    logic                 Overrun;

    typedef struct packed {
        logic [3:0][9:0] x;
        logic [3:0][9:0] y;
    } exp_t;

    exp_t exp_q[$];
    int   mx[4];
    int   my[4];
    int   checks = 0;
    int   errors = 0;

    obj_move_scheduler dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .FrameTick (FrameTick),
        .Enable    (Enable),
        .Direction (Direction),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .Grant     (Grant),
        .Busy      (Busy),
        .Done      (Done),
        .Overrun   (Overrun)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int step(input int c, input bit dec, input bit inc, input int mx_v);
        int r;
        r = c;
        if (dec && !inc) r = c - 1;
        else if (inc && !dec) r = c + 1;
        if (r < 0) r = 0;
        if (r > mx_v) r = mx_v;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mx[i] = 370;
            my[i] = 240;
        end
    endtask

    task automatic check_pos(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_x"}, int'(x_pos[i]), mx[i]);
            check({tag, "_y"}, int'(y_pos[i]), my[i]);
        end
    endtask

    // One scheduling round; tick_at>0 re-pulses FrameTick k cycles after the first.
    task automatic do_round(input logic [3:0] en, input logic [3:0][3:0] dir, input int tick_at);
        exp_t e;
        exp_t got;
        int   dones;
        int   ovr;
        bit   up, dn, lf, rt;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                up = dir[i][3]; dn = dir[i][2]; lf = dir[i][1]; rt = dir[i][0];
`ifndef OBJ_MOVE_DIAGONAL_EN
                if (up ^ dn) begin
                    lf = 1'b0;
                    rt = 1'b0;
                end
`endif
                mx[i] = step(mx[i], lf, rt, 639);
                my[i] = step(my[i], up, dn, 479);
            end
            e.x[i] = 10'(mx[i]);
            e.y[i] = 10'(my[i]);
        end
        exp_q.push_back(e);

        dones = 0;
        ovr   = 0;
        Enable    = en;
        Direction = dir;
        FrameTick = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge Clock);
            #1;
            FrameTick = (tick_at != 0 && k == tick_at);
            if (k == 2) begin
                Direction = ~dir;
                Enable    = ~en;
            end
            if (Overrun) ovr++;
            if (k == 1) check("busy_latch", int'(Busy), 1);
            if (k >= 2 && k <= 5) check("grant_walk", int'(Grant), 1 << (k - 2));
            if (k == 9) check("busy_idle", int'(Busy), 0);
            if (Done) begin
                dones++;
                if (dones == 1) begin
                    check("done_latency", k, 6);
                    if (exp_q.size() == 0) begin
                        check("sb_nonempty", 0, 1);
                    end else begin
                        got.x = x_pos;
                        got.y = y_pos;
                        e = exp_q.pop_front();
                        for (int i = 0; i < 4; i++) begin
                            check("round_x", int'(got.x[i]), int'(e.x[i]));
                            check("round_y", int'(got.y[i]), int'(e.y[i]));
                        end
                    end
                end
            end
        end
        FrameTick = 1'b0;
        check("done_count", dones, 1);
        check("overrun_count", ovr, (tick_at != 0) ? 1 : 0);
    endtask

    initial begin
        Reset     = 1'b1;
        FrameTick = 1'b0;
        Enable    = '0;
        Direction = '0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        model_reset();

        // Reset state and idling.
        repeat (3) @(posedge Clock);
        #1;
        check("rst_busy", int'(Busy), 0);
        check("rst_grant", int'(Grant), 0);
        check("rst_done", int'(Done), 0);
        check("rst_overrun", int'(Overrun), 0);
        check_pos("rst");

        // Object 0 up+right; disabled objects carry directions that must be ignored.
        do_round(4'b0001, {4'b0100, 4'b0010, 4'b1010, 4'b1001}, 0);

        // All four directions cancel.
        do_round(4'b1111, {4'b1111, 4'b1111, 4'b1111, 4'b1111}, 0);

        // Second tick two cycles in: one step, one Done, one Overrun.
        do_round(4'b0001, {4'b0000, 4'b0000, 4'b0000, 4'b0010}, 2);

        // Tick landing in the DONE cycle is ignored but flagged.
        do_round(4'b0010, {4'b0000, 4'b0000, 4'b1000, 4'b0000}, 6);

        // Random rounds.
        for (int r = 0; r < 6; r++) begin
            do_round(4'($urandom), {4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom)}, 0);
        end

        // Drive object 1 left into x=0 and object 2 down into y=479.
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        model_reset();
        for (int r = 0; r < 373; r++) begin
            do_round(4'b0110, {4'b0000, 4'b0100, 4'b0010, 4'b0000}, 0);
        end
        check("clamp_x0", int'(x_pos[1]), 0);
        check("clamp_y479", int'(y_pos[2]), 479);

        // Reset while object 2 is granted.
        Enable    = 4'b1111;
        Direction = {4{4'b1001}};
        FrameTick = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge Clock);
            #1;
            FrameTick = 1'b0;
        end
        check("mid_grant", int'(Grant), 4'b0100);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        model_reset();
        check("mid_busy", int'(Busy), 0);
        check("mid_grant0", int'(Grant), 0);
        check_pos("mid_rst");
        repeat (8) @(posedge Clock);
        #1;
        check("mid_still_idle", int'(Busy), 0);
        check("mid_no_done", int'(Done), 0);
        check("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obj_move_scheduler.md
OBJ_MOVE_SCHEDULER -- requirements
Module: obj_move_scheduler

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- NUM_OBJ, 4: number of movable objects sharing the step datapath.
- X_MAX, 639: largest legal x coordinate.
- Y_MAX, 479: largest legal y coordinate.
- STEP, 1: pixels moved per granted update.
- X_INIT, 370: reset x of every object.
- Y_INIT, 240: reset y of every object.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- Clock, in, 1: the single clock; all logic on its rising edge.
- Reset, in, 1: synchronous, active-high reset.
- FrameTick, in, 1: one-cycle pulse per video frame that starts a scheduling round.
- Enable, in, NUM_OBJ: per-object move enable, sampled at LATCH.
- Direction, in, NUM_OBJ x 4: per object, bit3 Up, bit2 Down, bit1 Left, bit0 Right; sampled at LATCH.
- x_pos, out, NUM_OBJ x 10: registered x coordinate per object.
- y_pos, out, NUM_OBJ x 10: registered y coordinate per object.
- Grant, out, NUM_OBJ: one-hot, naming the object being updated this cycle; zero otherwise.
- Busy, out, 1: high in every state except IDLE.
- Done, out, 1: one-cycle pulse when a round completes.
- Overrun, out, 1: one-cycle pulse when FrameTick arrives while Busy.

Function
REQ-003 The FSM SHALL have four states: IDLE, LATCH, UPDATE, DONE.
REQ-004 IDLE SHALL go to LATCH on the cycle after FrameTick=1; otherwise it SHALL stay in IDLE.
REQ-005 LATCH SHALL copy Enable and Direction into internal registers, then go to UPDATE with object index 0.
REQ-006 UPDATE SHALL spend exactly one cycle per object, in ascending index order 0..NUM_OBJ-1.
REQ-007 During UPDATE, Grant SHALL equal the one-hot of the current index, and only that object's position SHALL change.
REQ-008 After index NUM_OBJ-1, UPDATE SHALL go to DONE; DONE SHALL pulse Done for one cycle and return to IDLE.
REQ-009 Round latency: FrameTick at cycle t SHALL give LATCH at t+1, UPDATE at t+2..t+1+NUM_OBJ, and Done at t+2+NUM_OBJ.
REQ-010 An object with a latched Enable=0 SHALL still be granted its UPDATE cycle, but its position SHALL be unchanged.
REQ-011 Up SHALL compute y-STEP; Down SHALL compute y+STEP; Left SHALL compute x-STEP; Right SHALL compute x+STEP.
REQ-012 Up and Down both set SHALL cancel vertical motion; Left and Right both set SHALL cancel horizontal motion.
REQ-013 Arithmetic SHALL be done at 11 bits, then clamped: a result below 0 SHALL become 0, and a result above X_MAX (or Y_MAX) SHALL become X_MAX (or Y_MAX).
REQ-014 Positions SHALL never wrap around.
REQ-015 A FrameTick while Busy=1 SHALL NOT restart or extend the round.
REQ-016 A FrameTick while Busy=1 SHALL pulse Overrun on the next cycle.
REQ-017 Changes to Direction or Enable after LATCH SHALL have no effect until the next round.
REQ-018 A FrameTick in the same cycle as DONE SHALL be ignored and SHALL raise Overrun, because Busy=1 in DONE.

Reset
REQ-019 Reset=1 SHALL put the FSM in IDLE on the next rising edge, including mid-round.
REQ-020 Reset SHALL set every x_pos to X_INIT and every y_pos to Y_INIT.
REQ-021 Reset SHALL clear Grant, Busy, Done, Overrun and all latched inputs to 0.
REQ-022 Reset SHALL take priority over FrameTick.

Configuration
REQ-023 The macro OBJ_MOVE_DIAGONAL_EN SHALL control diagonal motion.
REQ-024 With OBJ_MOVE_DIAGONAL_EN defined, vertical and horizontal steps SHALL both apply in the same UPDATE cycle.
REQ-025 With OBJ_MOVE_DIAGONAL_EN undefined, a net vertical move SHALL suppress the horizontal move for that object that round, so vertical has priority.

Structure
REQ-026 Package obj_move_pkg SHALL hold the dir_t packed struct (up, down, left, right), the state_t enum, and the default constants NUM_OBJ, X_MAX and Y_MAX.
REQ-027 Sub-module obj_step_clamp SHALL contain the combinational per-axis step-and-clamp logic, taking the current coordinate, direction bits and maximum and producing the next coordinate.
REQ-028 A single obj_step_clamp instance SHALL be time-shared across all objects through the Grant index.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset, then idle -> all x_pos=370, y_pos=240; Busy=0.
- Object 0: Enable=1, Direction=Up+Right, one FrameTick -> Done 6 cycles after the tick; obj0=(371,239) with diagonal enabled, (370,239) without; other objects unchanged.
- Object 1: x=0, Direction=Left, 3 ticks -> x stays 0 (no wrap to 1023). Object 2: y=479, Direction=Down -> y stays 479.
- Direction=Up+Down+Left+Right with Enable=1 -> position unchanged; Grant still walks 0001, 0010, 0100, 1000.
- Second FrameTick 2 cycles after the first -> Overrun pulses once; only one step is applied; Done pulses once.
- Reset asserted during the UPDATE cycle of object 2 -> next cycle state IDLE, all positions back to (370,240), Grant=0.
